// File: rtl/frame_checker.sv
// frame_checker: measures each frame's geometry and pixel statistics on the
// fval/lval/dval/pix_data bus. It flags width, height and protocol violations
// and presents one registered result set per completed frame.
module frame_checker #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned BPP    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           fval,
  input  logic           lval,
  input  logic           dval,
  input  logic [BPP-1:0] pix_data,
  output logic           frame_done,
  output logic [15:0]    meas_width,
  output logic [15:0]    meas_height,
  output logic [31:0]    pix_sum,
  output logic [BPP-1:0] pix_min,
  output logic [BPP-1:0] pix_max,
  output logic           err_width,
  output logic           err_height,
  output logic           err_proto,
  output logic [15:0]    frame_cnt
);

  localparam logic [15:0] WidthW  = 16'(WIDTH);
  localparam logic [15:0] HeightW = 16'(HEIGHT);

  typedef enum logic [1:0] {StSync, StIdle, StFrame, StReport} state_e;

  state_e         state_q, state_d;
  logic           fval_q, lval_q;
  logic           pend_q, pend_d;
  logic [15:0]    pix_cnt_q, pix_cnt_d;
  logic [15:0]    line_cnt_q, line_cnt_d;
  logic [15:0]    max_w_q, max_w_d;
  logic [31:0]    sum_q, sum_d;
  logic [BPP-1:0] min_q, min_d;
  logic [BPP-1:0] max_q, max_d;
  logic           ew_q, ew_d;
  logic           ep_q, ep_d;

  logic           frame_done_d;
  logic [15:0]    meas_width_d, meas_height_d, frame_cnt_d;
  logic [31:0]    pix_sum_d;
  logic [BPP-1:0] pix_min_d, pix_max_d;
  logic           err_width_d, err_height_d, err_proto_d;

  logic fval_rise, fval_fall, lval_fall, pix_acc, line_close, proto_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fval_rise  = fval & ~fval_q;
  assign fval_fall  = ~fval & fval_q;
  assign lval_fall  = ~lval & lval_q;
  assign pix_acc    = fval & lval & dval;
  // A line also closes when fval drops while the line is still open.
  assign line_close = (lval_fall & fval) | (fval_fall & lval_q);
  assign proto_bad  = (dval & ~lval) | (lval & ~fval);

  // Next-state, accumulator and result update.
  always_comb begin
    state_d       = state_q;
    pend_d        = 1'b0;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    max_w_d       = max_w_q;
    sum_d         = sum_q;
    min_d         = min_q;
    max_d         = max_q;
    ew_d          = ew_q;
    ep_d          = ep_q;
    frame_done_d  = 1'b0;
    meas_width_d  = meas_width;
    meas_height_d = meas_height;
    pix_sum_d     = pix_sum;
    pix_min_d     = pix_min;
    pix_max_d     = pix_max;
    err_width_d   = err_width;
    err_height_d  = err_height;
    err_proto_d   = err_proto;
    frame_cnt_d   = frame_cnt;

    if (!en) begin
      // Disabled: drop any frame in flight, outputs hold.
      state_d = StSync;
    end else begin
      unique case (state_q)
        StSync: begin
          if (!fval) state_d = StIdle;
        end
        StIdle: begin
          // pend_q covers a frame whose rising edge was seen during REPORT.
          if (fval_rise || (pend_q && fval)) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            max_w_d    = '0;
            sum_d      = '0;
            min_d      = '1;
            max_d      = '0;
            ew_d       = 1'b0;
            ep_d       = 1'b0;
            state_d    = StFrame;
          end
        end
        StFrame: begin
          if (pix_acc) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
            sum_d     = sum_q + 32'(pix_data);
            if (pix_data < min_q) min_d = pix_data;
            if (pix_data > max_q) max_d = pix_data;
          end
          if (line_close) begin
            line_cnt_d = sat_inc(line_cnt_q);
            if (pix_cnt_q != WidthW) ew_d = 1'b1;
            if (pix_cnt_q > max_w_q) max_w_d = pix_cnt_q;
            pix_cnt_d = '0;
          end
          if (proto_bad) ep_d = 1'b1;
          if (fval_fall) state_d = StReport;
        end
        StReport: begin
          frame_done_d  = 1'b1;
          meas_width_d  = max_w_q;
          meas_height_d = line_cnt_q;
          pix_sum_d     = sum_q;
          pix_min_d     = min_q;
          pix_max_d     = max_q;
          err_width_d   = ew_q;
          err_height_d  = (line_cnt_q != HeightW);
          err_proto_d   = ep_q;
          frame_cnt_d   = frame_cnt + 16'd1;
          pend_d        = fval_rise;
          state_d       = StIdle;
        end
        default: state_d = StSync;
      endcase
    end
  end

  // State, edge-detect copies, accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StSync;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      pend_q      <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      max_w_q     <= '0;
      sum_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      ew_q        <= 1'b0;
      ep_q        <= 1'b0;
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      pix_sum     <= '0;
      pix_min     <= '1;
      pix_max     <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
      err_proto   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval;
      lval_q      <= lval;
      pend_q      <= pend_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      max_w_q     <= max_w_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      ew_q        <= ew_d;
      ep_q        <= ep_d;
      frame_done  <= frame_done_d;
      meas_width  <= meas_width_d;
      meas_height <= meas_height_d;
      pix_sum     <= pix_sum_d;
      pix_min     <= pix_min_d;
      pix_max     <= pix_max_d;
      err_width   <= err_width_d;
      err_height  <= err_height_d;
      err_proto   <= err_proto_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker: drives whole frames, predicts each frame's results
// into a scoreboard queue and compares them when frame_done pulses.
module tb_frame_checker;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int unsigned B = 8;

  logic         clk = 1'b0;
  logic         rst, en, fval, lval, dval;
  logic [B-1:0] pix_data;
  logic         frame_done;
  logic [15:0]  meas_width, meas_height, frame_cnt;
  logic [31:0]  pix_sum;
  logic [B-1:0] pix_min, pix_max;
  logic         err_width, err_height, err_proto;

  frame_checker #(.WIDTH(W), .HEIGHT(H), .BPP(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fval       (fval),
    .lval       (lval),
    .dval       (dval),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .meas_width (meas_width),
    .meas_height(meas_height),
    .pix_sum    (pix_sum),
    .pix_min    (pix_min),
    .pix_max    (pix_max),
    .err_width  (err_width),
    .err_height (err_height),
    .err_proto  (err_proto),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]  w;
    logic [15:0]  h;
    logic [31:0]  sum;
    logic [B-1:0] mn;
    logic [B-1:0] mx;
    logic         ew;
    logic         eh;
    logic         ep;
    logic [15:0]  fc;
    int           drop_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  exp_t        mon_e;
  logic [15:0] exp_fc;
  logic        done_prev = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.w = '0; e.h = '0; e.sum = '0; e.mn = '1; e.mx = '0;
    e.ew = 1'b0; e.eh = 1'b0; e.ep = 1'b0; e.fc = '0; e.drop_cyc = 0;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, ".meas_width"},  meas_width,  e.w);
    check_eq({tag, ".meas_height"}, meas_height, e.h);
    check_eq({tag, ".pix_sum"},     pix_sum,     e.sum);
    check_eq({tag, ".pix_min"},     pix_min,     e.mn);
    check_eq({tag, ".pix_max"},     pix_max,     e.mx);
    check_eq({tag, ".err_width"},   err_width,   e.ew);
    check_eq({tag, ".err_height"},  err_height,  e.eh);
    check_eq({tag, ".err_proto"},   err_proto,   e.ep);
    check_eq({tag, ".frame_cnt"},   frame_cnt,   e.fc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every frame_done pops one prediction; none may be spare.
  always @(negedge clk) begin
    if (frame_done) begin
      check_eq("done_single", done_prev, 1'b0);
      if (sb.size() == 0) begin
        check_eq("unexpected_done", frame_done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check_outputs("frame", mon_e);
        check_eq("done_latency", cyc - mon_e.drop_cyc, 2);
      end
    end
    done_prev <= frame_done;
  end

  // One frame: 2-cycle front porch, lines of len pixels with 2-cycle blanking,
  // then fval low for gap cycles. Optional glitch, en raise and reset.
  task automatic drive_frame(input int nlines, input int short_line, input int base,
                             input bit glitch, input bit expect_done, input int en_line,
                             input int rst_line, input int gap);
    exp_t         e;
    logic [B-1:0] v;
    int           len;
    e = reset_exp();
    v = B'(base);
    fval = 1'b1;
    step();
    step();
    for (int i = 0; i < nlines; i++) begin
      if (i == en_line) en = 1'b1;
      if (i == rst_line) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_outputs("after_rst", reset_exp());
        check_eq("after_rst.frame_done", frame_done, 1'b0);
        exp_fc   = '0;
        last_exp = reset_exp();
      end
      len = (i == short_line) ? W - 1 : W;
      if (len != W) e.ew = 1'b1;
      if (16'(len) > e.w) e.w = 16'(len);
      for (int p = 0; p < len; p++) begin
        lval = 1'b1;
        dval = 1'b1;
        pix_data = v;
        e.sum = e.sum + 32'(v);
        if (v < e.mn) e.mn = v;
        if (v > e.mx) e.mx = v;
        v = v + 1'b1;
        step();
      end
      lval = 1'b0;
      dval = 1'b0;
      if (glitch && i == 1) begin
        dval = 1'b1;
        pix_data = 8'hFE;
      end
      step();
      dval = 1'b0;
      step();
    end
    fval = 1'b0;
    if (expect_done) begin
      exp_fc     = exp_fc + 16'd1;
      e.h        = 16'(nlines);
      e.eh       = (nlines != H);
      e.ep       = glitch;
      e.fc       = exp_fc;
      e.drop_cyc = cyc;
      sb.push_back(e);
      last_exp = e;
    end
    repeat (gap) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_data = '0;
    exp_fc = '0;
    last_exp = reset_exp();
    step();
    step();
    check_outputs("reset", reset_exp());
    check_eq("reset.frame_done", frame_done, 1'b0);
    rst = 1'b0;
    step();

    // Nominal frame, values 0..31.
    drive_frame(4, -1, 0, 1'b0, 1'b1, -1, -1, 3);
    check_eq("nominal.pix_sum", pix_sum, 32'd496);
    check_eq("nominal.pix_max", pix_max, 8'd31);
    // Short line, extra line, protocol glitch.
    drive_frame(4, 1, 0, 1'b0, 1'b1, -1, -1, 3);
    drive_frame(5, -1, 20, 1'b0, 1'b1, -1, -1, 3);
    drive_frame(4, -1, 5, 1'b1, 1'b1, -1, -1, 3);
    // Back-to-back frames at the minimum fval low time.
    drive_frame(4, -1, 40, 1'b0, 1'b1, -1, -1, 2);
    drive_frame(4, -1, 100, 1'b0, 1'b1, -1, -1, 3);

    // Disabled for one frame: no pulse, outputs hold.
    en = 1'b0;
    drive_frame(4, -1, 60, 1'b0, 1'b0, -1, -1, 3);
    check_outputs("hold", last_exp);
    en = 1'b1;
    step();

    // Reset in the middle of a frame.
    drive_frame(4, -1, 70, 1'b0, 1'b0, -1, 2, 3);
    check_outputs("post_rst", reset_exp());

    // Enable raised mid-frame: that frame is dropped, next two are reported.
    en = 1'b0;
    step();
    drive_frame(4, -1, 80, 1'b0, 1'b0, 2, -1, 3);
    drive_frame(4, -1, 90, 1'b0, 1'b1, -1, -1, 3);
    drive_frame(4, -1, 130, 1'b0, 1'b1, -1, -1, 3);
    check_eq("final.frame_cnt", frame_cnt, 16'd2);

    repeat (5) step();
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
